branch_resolve_queue: RTL
=========================

// Module: branch_resolve_queue
// PURPOSE
//  Downstream of the 2-bit saturating branch predictor. Holds predictions in flight, oldest first.
//  On each in-order branch resolution it pops the oldest entry, compares prediction with actual outcome,
//  drives the predictor's update strobe (result/taken), and raises mispredict/flush.
//  A mispredict discards every younger in-flight prediction.
// PARAMETERS
//  DEPTH   4    in-flight prediction entries; power of two, >=2
//  PTR_W   2    log2(DEPTH)
//  CNT_W   16   width of mispredict statistics counter
// PORTS
//  clk           in   1      rising-edge clock, single clock domain
//  rst           in   1      synchronous, active-high reset
//  pred_valid    in   1      predictor has produced a prediction this cycle
//  pred_taken    in   1      predicted direction (1 = taken)
//  resolve_valid in   1      oldest in-flight branch resolved this cycle
//  resolve_taken in   1      actual direction of that branch
//  result        out  1      1-cycle update strobe to predictor
//  taken         out  1      actual outcome sent with result
//  mispredict    out  1      1-cycle pulse, aligned with result
//  flush         out  1      1-cycle pulse, equal to mispredict; upstream squashes fetch
//  full          out  1      count == DEPTH
//  empty         out  1      count == 0
//  count         out  PTR_W+1  occupancy, 0..DEPTH
//  resolve_err   out  1      1-cycle pulse: resolve_valid while empty
//  mispred_cnt   out  CNT_W  total mispredicts, saturating
// BEHAVIOUR
//  Reset: all outputs 0 except empty = 1. Pointers, count and mispred_cnt cleared. Storage contents don't care.
//  Enqueue: at an edge with pred_valid && !full, write pred_taken at wr_ptr, wr_ptr+1 (wraps mod DEPTH).
//   pred_valid && full: entry dropped, no state change (upstream must not request while full).
//  Resolve: at an edge with resolve_valid && !empty:
//   - pop head
//   - register result = 1, taken = resolve_taken, mispredict = (head != resolve_taken).
//   - Latency: outputs high exactly 1 cycle after resolve_valid, then low unless another resolve.
//   - resolve_valid while empty: no pop, no result, resolve_err = 1 next cycle.
//  Mispredict flush, same edge as the resolving pop:
//   - wr_ptr = rd_ptr = 0, count = 0
//   - a same-cycle enqueue is discarded (it is younger)
//   - flush = 1 next cycle; mispred_cnt += 1, holds at all-ones.
//  Simultaneous enqueue + resolve, no mispredict: both happen, count unchanged.
//   Legal when full: pop frees the slot in the same edge.
//  Count: +1 on enqueue only, -1 on pop only, 0 on both or flush; never exceeds DEPTH or goes below 0.
//  full, empty and count are registered and reflect post-edge state.
//  Reset mid-operation: rst has priority over every event; all in-flight entries lost; no result pulse.
//  No FSM beyond the queue; the single control state is the occupancy. Pulses are never stretched.
// STRUCTURE
//  Shared package branch_pkg:
//   - 2-bit counter state encodings SNT = 0, WNT = 1, WT = 2, ST = 3 (shared with predictor)
//   - default DEPTH and CNT_W.
//  One sub-module: brq_fifo
//   - sync FIFO, 1-bit data, push/pop/clear, full/empty/count.
//   - Top level holds compare, pulse registers and statistics counter.
// TESTING
//  1 Reset: rst high 2 cycles
//    -> empty = 1, full = 0, count = 0, result = mispredict = flush = 0, mispred_cnt = 0.
//  2 Enqueue 1,1,0,1, then resolve 1,1,0,1
//    -> four result pulses, taken = 1,1,0,1, mispredict never set, count 4 -> 0, empty = 1 at end.
//  3 Enqueue 1,0,0; resolve 0 (head mispredicted)
//    -> next cycle result = 1, taken = 0, mispredict = flush = 1, count = 0, mispred_cnt = 1.
//    -> A same-cycle pred_valid is dropped.
//  4 Fill to DEPTH = 4, pred_valid again -> dropped, count stays 4.
//    Then enqueue + correct resolve together -> count stays 4, pointers wrap to 0 correctly.
//  5 resolve_valid while empty -> resolve_err = 1 for one cycle, result = 0, count = 0.
//  6 Enqueue 3 entries, assert rst during a resolve -> no result pulse, empty = 1, mispred_cnt = 0.
//    Force 65535 mispredicts -> mispred_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor and its resolve queue.
package branch_pkg;

  // 2-bit saturating predictor counter encodings (shared with the predictor).
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_state_e;

  localparam int BRQ_DEPTH_DEF = 4;
  localparam int BRQ_CNT_W_DEF = 16;

endpackage

// File: rtl/brq_fifo.sv
// Synchronous FIFO of 1-bit predictions with push/pop and a priority clear.
// The caller only asserts push when there is room (or a same-edge pop) and
// only asserts pop when the FIFO is not empty.
module brq_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Next pointers and occupancy; clear wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care after reset or clear.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds in-flight branch predictions oldest first, resolves them in order,
// drives the predictor update strobe and flushes younger entries on mispredict.
// Handshake: pred_valid and resolve_valid are single-cycle valid strobes with
// no ready; pred_valid is ignored while full unless a pop frees the slot on
// the same edge, and resolve_valid while empty is reported via resolve_err.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = BRQ_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             result,
  output logic             taken,
  output logic             mispredict,
  output logic             flush,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             resolve_err,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic head;
  logic pop, mis, push;

  logic             result_q, taken_q, mis_q, err_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  // Pop the oldest entry on a legal resolve; a mispredict squashes any
  // same-cycle enqueue because that prediction is younger.
  always_comb begin
    pop  = resolve_valid && !empty;
    mis  = pop && (head != resolve_taken);
    push = pred_valid && !mis && (!full || pop);
  end

  brq_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (pred_taken),
    .pop_i   (pop),
    .clear_i (mis),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // One-cycle result/mispredict/error pulses and saturating mispredict count.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q      <= 1'b0;
      taken_q       <= 1'b0;
      mis_q         <= 1'b0;
      err_q         <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      result_q <= pop;
      taken_q  <= pop && resolve_taken;
      mis_q    <= mis;
      err_q    <= resolve_valid && empty;
      if (mis && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
    end
  end

  assign result      = result_q;
  assign taken       = taken_q;
  assign mispredict  = mis_q;
  assign flush       = mis_q;
  assign resolve_err = err_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
